// File: rtl/icmp_echo_sc.sv
`default_nettype none
// ============================================================================
// Module   : icmp_echo_sc
// Brief    : Single-clock ICMP responder. Replies to echo requests, flags
//            destination-unreachable, and counts discarded requests.
// Revision : 1.0
// ============================================================================
module icmp_echo_sc #(
    parameter int DEPTH_LOG2  = 11,
    parameter bit VERIFY_CSUM = 1'b1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx_enable,
    input  logic [7:0]           i_rx_data,
    input  logic [47:0]          i_remote_mac,
    input  logic [31:0]          i_remote_ip,
    input  logic                 i_tx_enable,
    output logic                 o_tx_request,
    output logic                 o_tx_active,
    output logic [7:0]           o_tx_data,
    output logic [15:0]          o_length,
    output logic [47:0]          o_destination_mac,
    output logic [31:0]          o_destination_ip,
    output logic                 o_dst_unreachable,
    output logic [CNT_WIDTH-1:0] o_drop_count
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHECK   = 3'd3,
        S_TXREQ   = 3'd4,
        S_TX      = 3'd5,
        S_DISCARD = 3'd6
    } state_t;

    localparam logic [DEPTH_LOG2:0] c_WPTR_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [7:0]          c_TYPE_ECHO    = 8'd8;
    localparam logic [7:0]          c_TYPE_UNREACH = 8'd3;

    state_t               r_state;
    logic [7:0]           r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2:0]  r_wptr;
    logic [DEPTH_LOG2:0]  r_rptr;
    logic [31:0]          r_sum;
    logic [31:0]          r_psum;
    logic [1:0]           r_hdr_cnt;
    logic [15:0]          r_txidx;
    logic [15:0]          r_csum;
    logic [15:0]          r_length;
    logic [7:0]           r_rd_data;
    logic                 r_rx_prev;
    logic                 r_tx_request;
    logic                 r_unreach;
    logic [47:0]          r_mac;
    logic [31:0]          r_ip;
    logic [CNT_WIDTH-1:0] r_drop;

    logic                 w_rx_start;
    logic                 w_busy;
    logic                 w_overflow;
    logic                 w_wr_en;
    logic                 w_bad_csum;
    logic                 w_grant;
    logic [1:0]           w_drop_inc;
    logic [CNT_WIDTH:0]   w_drop_sum;
    logic [15:0]          w_fold;
    logic [15:0]          w_pfold;
    logic [31:0]          w_byte_hi;
    logic [31:0]          w_byte_lo;

    function automatic logic [15:0] fold16(input logic [31:0] s);
        logic [16:0] t;
        t = {1'b0, s[15:0]} + {1'b0, s[31:16]};
        return t[15:0] + {15'd0, t[16]};
    endfunction

    // Packets only start on a rising rx_enable, so one that began while busy
    // stays ignored until it ends.
    assign w_rx_start = i_rx_enable && !r_rx_prev;
    assign w_busy     = (r_state == S_CHECK) || (r_state == S_TXREQ) || (r_state == S_TX);
    assign w_overflow = (r_state == S_PAYLOAD) && i_rx_enable && (r_wptr == c_WPTR_FULL);
    assign w_wr_en    = (r_state == S_PAYLOAD) && i_rx_enable && (r_wptr != c_WPTR_FULL);
    assign w_fold     = fold16(r_sum);
    assign w_pfold    = fold16(r_psum);
    assign w_bad_csum = VERIFY_CSUM && (r_state == S_CHECK) && (w_fold != 16'hFFFF);
    assign w_grant    = (r_state == S_TXREQ) && i_tx_enable;
    assign w_byte_hi  = {16'd0, i_rx_data, 8'd0};
    assign w_byte_lo  = {24'd0, i_rx_data};
    assign w_drop_inc = {1'b0, w_overflow | w_bad_csum}
                      + {1'b0, w_busy && w_rx_start && (i_rx_data == c_TYPE_ECHO)};
    assign w_drop_sum = {1'b0, r_drop} + {{(CNT_WIDTH-1){1'b0}}, w_drop_inc};

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= i_rx_data;
        r_rd_data <= r_mem[r_rptr[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_sum        <= '0;
            r_psum       <= '0;
            r_hdr_cnt    <= '0;
            r_txidx      <= '0;
            r_csum       <= '0;
            r_length     <= '0;
            r_rx_prev    <= 1'b0;
            r_tx_request <= 1'b0;
            r_unreach    <= 1'b0;
            r_mac        <= '0;
            r_ip         <= '0;
            r_drop       <= '0;
        end else begin
            r_rx_prev <= i_rx_enable;
            r_unreach <= w_busy && w_rx_start && (i_rx_data == c_TYPE_UNREACH);
            r_drop    <= w_drop_sum[CNT_WIDTH] ? '1 : w_drop_sum[CNT_WIDTH-1:0];
            case (r_state)
                S_IDLE: begin
                    if (w_rx_start) begin
                        r_mac     <= i_remote_mac;
                        r_ip      <= i_remote_ip;
                        r_wptr    <= '0;
                        r_sum     <= w_byte_hi;
                        r_psum    <= '0;
                        r_hdr_cnt <= 2'd1;
                        if (i_rx_data == c_TYPE_ECHO) begin
                            r_state <= S_HEADER;
                        end else begin
                            r_unreach <= (i_rx_data == c_TYPE_UNREACH);
                            r_state   <= S_DISCARD;
                        end
                    end
                end
                S_HEADER: begin
                    if (!i_rx_enable) begin
                        r_state <= S_IDLE;
                    end else if (r_hdr_cnt == 2'd1 && i_rx_data != 8'h00) begin
                        r_state <= S_DISCARD;
                    end else begin
                        r_sum     <= r_sum + ((r_hdr_cnt == 2'd2) ? w_byte_hi : w_byte_lo);
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                        if (r_hdr_cnt == 2'd3) r_state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!i_rx_enable) begin
                        r_state <= S_CHECK;
                    end else if (w_overflow) begin
                        r_state <= S_DISCARD;
                    end else begin
                        // Payload starts at ICMP offset 4, so even pointer = high byte.
                        r_sum  <= r_sum  + (r_wptr[0] ? w_byte_lo : w_byte_hi);
                        r_psum <= r_psum + (r_wptr[0] ? w_byte_lo : w_byte_hi);
                        r_wptr <= r_wptr + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_rptr  <= '0;
                    r_txidx <= '0;
                    if (w_bad_csum) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_csum       <= ~w_pfold;
                        r_length     <= 16'd4 + 16'(r_wptr);
                        r_tx_request <= 1'b1;
                        r_state      <= S_TXREQ;
                    end
                end
                S_TXREQ: begin
                    if (i_tx_enable) begin
                        r_tx_request <= 1'b0;
                        r_txidx      <= 16'd1;
                        r_state      <= S_TX;
                    end
                end
                S_TX: begin
                    r_txidx <= r_txidx + 16'd1;
                    // Read runs one byte ahead so payload[0] lands on byte 4.
                    if (r_txidx >= 16'd3) r_rptr <= r_rptr + 1'b1;
                    if (r_txidx == r_length - 16'd1) r_state <= S_IDLE;
                end
                S_DISCARD: begin
                    if (!i_rx_enable) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_tx_data = 8'h00;
        if (r_state == S_TX) begin
            case (r_txidx)
                16'd1:   o_tx_data = 8'h00;
                16'd2:   o_tx_data = r_csum[15:8];
                16'd3:   o_tx_data = r_csum[7:0];
                default: o_tx_data = r_rd_data;
            endcase
        end
    end

    assign o_tx_active       = w_grant || (r_state == S_TX);
    assign o_tx_request      = r_tx_request;
    assign o_length          = r_length;
    assign o_destination_mac = r_mac;
    assign o_destination_ip  = r_ip;
    assign o_dst_unreachable = r_unreach;
    assign o_drop_count      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_icmp_echo_sc.sv
`default_nettype none
// ============================================================================
// Module   : tb_icmp_echo_sc
// Brief    : Self-checking bench for icmp_echo_sc; two instances with
//            different depth / verify / counter-width settings.
// Revision : 1.0
// ============================================================================
module tb_icmp_echo_sc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rx_en   [2];
    logic [7:0]  rx_d    [2];
    logic [47:0] rmac    [2];
    logic [31:0] rip     [2];
    logic        tx_en   [2];
    logic        tx_req  [2];
    logic        tx_act  [2];
    logic        unreach [2];
    logic [7:0]  tx_d    [2];
    logic [15:0] len     [2];
    logic [47:0] dmac    [2];
    logic [31:0] dip     [2];
    logic [15:0] drop0;
    logic [1:0]  drop1;

    int tests = 0;
    int fails = 0;
    int unr_cnt [2] = '{0, 0};
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] cmp_e;
    logic [7:0] pl1 [$], pl3 [$], pl5 [$], pl16 [$], pl17 [$], plu [$], lit [$], tmp [$];

    icmp_echo_sc #(.DEPTH_LOG2(11), .VERIFY_CSUM(1'b1), .CNT_WIDTH(16)) u_a (
        .clk(clk), .rst(rst),
        .i_rx_enable(rx_en[0]), .i_rx_data(rx_d[0]),
        .i_remote_mac(rmac[0]), .i_remote_ip(rip[0]),
        .i_tx_enable(tx_en[0]),
        .o_tx_request(tx_req[0]), .o_tx_active(tx_act[0]), .o_tx_data(tx_d[0]),
        .o_length(len[0]), .o_destination_mac(dmac[0]), .o_destination_ip(dip[0]),
        .o_dst_unreachable(unreach[0]), .o_drop_count(drop0)
    );

    icmp_echo_sc #(.DEPTH_LOG2(4), .VERIFY_CSUM(1'b0), .CNT_WIDTH(2)) u_b (
        .clk(clk), .rst(rst),
        .i_rx_enable(rx_en[1]), .i_rx_data(rx_d[1]),
        .i_remote_mac(rmac[1]), .i_remote_ip(rip[1]),
        .i_tx_enable(tx_en[1]),
        .o_tx_request(tx_req[1]), .o_tx_active(tx_act[1]), .o_tx_data(tx_d[1]),
        .o_length(len[1]), .o_destination_mac(dmac[1]), .o_destination_ip(dip[1]),
        .o_dst_unreachable(unreach[1]), .o_drop_count(drop1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Internet checksum over a byte list, odd tail padded with zero.
    function automatic logic [15:0] ocsum(input logic [7:0] b[$]);
        logic [31:0] s;
        logic [7:0]  lo;
        s = 32'd0;
        for (int i = 0; i < b.size(); i += 2) begin
            lo = (i + 1 < b.size()) ? b[i+1] : 8'h00;
            s  = s + {16'd0, b[i], lo};
        end
        while (s > 32'h0000_FFFF) s = (s & 32'h0000_FFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    task automatic send(input int d, input logic [7:0] ty, input logic [7:0] pl[$],
                        input bit corrupt, input logic [47:0] mac, input logic [31:0] ip);
        logic [7:0]  m [$];
        logic [15:0] c;
        m.push_back(ty); m.push_back(8'h00); m.push_back(8'h00); m.push_back(8'h00);
        foreach (pl[i]) m.push_back(pl[i]);
        c = ocsum(m);
        if (corrupt) c = c ^ 16'h0100;
        m[2] = c[15:8];
        m[3] = c[7:0];
        for (int i = 0; i < m.size(); i++) begin
            @(posedge clk); #1;
            rx_en[d] = 1'b1;
            rx_d[d]  = m[i];
            rmac[d]  = (i == 0) ? mac : ~mac;
            rip[d]   = (i == 0) ? ip  : ~ip;
        end
        @(posedge clk); #1;
        rx_en[d] = 1'b0;
        rx_d[d]  = 8'h00;
    endtask

    task automatic expect_reply(input int d, input logic [7:0] pl[$]);
        logic [7:0]  r [$];
        logic [15:0] c;
        for (int i = 0; i < 4; i++) r.push_back(8'h00);
        foreach (pl[i]) r.push_back(pl[i]);
        c = ocsum(r);
        r[2] = c[15:8];
        r[3] = c[7:0];
        foreach (r[i]) begin
            if (d == 0) q0.push_back(r[i]);
            else        q1.push_back(r[i]);
        end
    endtask

    task automatic grant(input int d, input int exp_len, input logic [47:0] mac, input logic [31:0] ip);
        int n = 0;
        do begin @(negedge clk); n++; end while (tx_req[d] !== 1'b1 && n < 200);
        check("req_wait", 64'(n < 200), 64'd1);
        check("length", 64'(len[d]), 64'(exp_len));
        check("dst_mac", 64'(dmac[d]), 64'(mac));
        check("dst_ip", 64'(dip[d]), 64'(ip));
        @(posedge clk); #1 tx_en[d] = 1'b1;
        @(posedge clk); #1 tx_en[d] = 1'b0;
        check("req_clear", 64'(tx_req[d]), 64'd0);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        do begin @(negedge clk); n++; end while (tx_act[d] === 1'b1 && n < 5000);
        check("tx_done_wait", 64'(n < 5000), 64'd1);
        check("reply_bytes_left", 64'((d == 0) ? q0.size() : q1.size()), 64'd0);
    endtask

    task automatic idle_check(input int d, input int exp_unr);
        repeat (10) @(negedge clk);
        check("no_request", 64'(tx_req[d]), 64'd0);
        check("unreach_cycles", 64'(unr_cnt[d]), 64'(exp_unr));
    endtask

    // Byte-stream compare: every active cycle must match the next expected byte.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                if (unreach[d] === 1'b1) unr_cnt[d]++;
                tests++;
                if (tx_act[d] === 1'b1) begin
                    if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                        fails++;
                        $display("FAIL tx_extra dut%0d: got byte %0h expected no active byte", d, tx_d[d]);
                    end else begin
                        if (d == 0) cmp_e = q0.pop_front();
                        else        cmp_e = q1.pop_front();
                        if (tx_d[d] !== cmp_e) begin
                            fails++;
                            $display("FAIL tx_byte dut%0d: got %0h expected %0h", d, tx_d[d], cmp_e);
                        end
                    end
                end else if (tx_d[d] !== 8'h00) begin
                    fails++;
                    $display("FAIL tx_idle_data dut%0d: got %0h expected 0", d, tx_d[d]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rx_en[d] = 1'b0; rx_d[d] = 8'h00; rmac[d] = '0; rip[d] = '0; tx_en[d] = 1'b0;
        end
        pl1 = {8'h12, 8'h34, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pl3 = {8'h12, 8'h34, 8'h00, 8'h02, 8'hAA};
        pl5 = {8'hAB, 8'hCD, 8'h00, 8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        plu = {8'h00, 8'h00, 8'h00, 8'h00, 8'h45, 8'h00};
        for (int i = 0; i < 17; i++) pl17.push_back(8'(i * 7 + 3));
        for (int i = 0; i < 16; i++) pl16.push_back(8'(i * 7 + 3));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            check("rst_tx_request", 64'(tx_req[d]), 64'd0);
            check("rst_tx_active", 64'(tx_act[d]), 64'd0);
            check("rst_length", 64'(len[d]), 64'd0);
            check("rst_unreach", 64'(unreach[d]), 64'd0);
        end
        check("rst_drop_a", 64'(drop0), 64'd0);
        check("rst_drop_b", 64'(drop1), 64'd0);

        // Pin the checksum model to hand-computed values.
        tmp = {8'h08, 8'h00, 8'h00, 8'h00};
        foreach (pl1[i]) tmp.push_back(pl1[i]);
        check("model_req_csum", 64'(ocsum(tmp)), 64'h482D);
        tmp = {8'h00, 8'h00, 8'h00, 8'h00};
        foreach (pl3[i]) tmp.push_back(pl3[i]);
        check("model_odd_csum", 64'(ocsum(tmp)), 64'h43C9);

        // Valid echo, reply bytes fully hand-computed.
        lit = {8'h00, 8'h00, 8'h50, 8'h2D, 8'h12, 8'h34, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        foreach (lit[i]) q0.push_back(lit[i]);
        send(0, 8'd8, pl1, 1'b0, 48'h0200_0000_0001, 32'hC0A8_0001);
        grant(0, 12, 48'h0200_0000_0001, 32'hC0A8_0001);
        wait_done(0);

        // Corrupted checksum: verifying instance drops, other one replies.
        send(0, 8'd8, pl1, 1'b1, 48'h0200_0000_0002, 32'hC0A8_0002);
        idle_check(0, 0);
        check("drop_bad_csum", 64'(drop0), 64'd1);
        expect_reply(1, pl1);
        send(1, 8'd8, pl1, 1'b1, 48'h0200_0000_0003, 32'hC0A8_0003);
        grant(1, 12, 48'h0200_0000_0003, 32'hC0A8_0003);
        wait_done(1);
        check("no_verify_drop", 64'(drop1), 64'd0);

        // Odd payload, zero-padded checksum.
        expect_reply(0, pl3);
        send(0, 8'd8, pl3, 1'b0, 48'h0200_0000_0004, 32'hC0A8_0004);
        grant(0, 9, 48'h0200_0000_0004, 32'hC0A8_0004);
        wait_done(0);

        // Depth-16 buffer: 17 bytes overflow, 16 fit; counter saturates at 3.
        send(1, 8'd8, pl17, 1'b0, 48'h0200_0000_0005, 32'hC0A8_0005);
        idle_check(1, 0);
        check("drop_overflow", 64'(drop1), 64'd1);
        expect_reply(1, pl16);
        send(1, 8'd8, pl16, 1'b0, 48'h0200_0000_0006, 32'hC0A8_0006);
        grant(1, 20, 48'h0200_0000_0006, 32'hC0A8_0006);
        wait_done(1);
        for (int k = 0; k < 3; k++) begin
            send(1, 8'd8, pl17, 1'b0, 48'h0200_0000_0007, 32'hC0A8_0007);
            repeat (4) @(negedge clk);
            check("drop_saturate", 64'(drop1), (k == 0) ? 64'd2 : 64'd3);
        end

        // Destination unreachable.
        send(0, 8'd3, plu, 1'b0, 48'h0200_0000_0008, 32'hC0A8_0008);
        idle_check(0, 1);
        check("unreach_no_drop", 64'(drop0), 64'd1);

        // Echo request arriving mid-reply is dropped; reply is intact.
        expect_reply(0, pl5);
        send(0, 8'd8, pl5, 1'b0, 48'h0200_0000_0009, 32'hC0A8_0009);
        fork
            begin
                grant(0, 14, 48'h0200_0000_0009, 32'hC0A8_0009);
                wait_done(0);
            end
            begin
                repeat (4) @(posedge clk);
                send(0, 8'd8, pl1, 1'b0, 48'h0200_0000_000A, 32'hC0A8_000A);
            end
        join
        idle_check(0, 1);
        check("drop_busy", 64'(drop0), 64'd2);

        // Reset during reply byte 6, then a fresh echo.
        expect_reply(0, pl5);
        send(0, 8'd8, pl5, 1'b0, 48'h0200_0000_000B, 32'hC0A8_000B);
        grant(0, 14, 48'h0200_0000_000B, 32'hC0A8_000B);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        check("rst_mid_tx_active", 64'(tx_act[0]), 64'd0);
        check("rst_mid_tx_data", 64'(tx_d[0]), 64'd0);
        check("rst_mid_drop_a", 64'(drop0), 64'd0);
        check("rst_mid_drop_b", 64'(drop1), 64'd0);
        check("rst_mid_request", 64'(tx_req[0]), 64'd0);
        expect_reply(0, pl1);
        send(0, 8'd8, pl1, 1'b0, 48'h0200_0000_000C, 32'hC0A8_000C);
        grant(0, 12, 48'h0200_0000_000C, 32'hC0A8_000C);
        wait_done(0);
        check("final_unreach_b", 64'(unr_cnt[1]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/icmp_echo_sc.md
Name: icmp_echo_sc

Overview:
- Single-clock, parametrised ICMP responder for the Ethernet stack. It sits between the IP receive demux and the transmit arbiter.
- Answers echo requests (type 8) with echo replies (type 0) and flags destination-unreachable (type 3).
- Generalises the dual-clock ICMP block with:
  - configurable payload depth;
  - optional incoming-checksum verification;
  - odd-length checksum padding;
  - a saturating drop counter.

Parameters:
DEPTH_LOG2, 11, payload buffer holds 2**DEPTH_LOG2 bytes (id+seq+data)
VERIFY_CSUM, 1, 1 = drop requests whose ICMP checksum is invalid; 0 = accept all
CNT_WIDTH, 16, width of drop_count

Ports:
clock  in  1  sole clock; rx and tx both on this domain
reset  in  1  synchronous, active-high
rx_enable  in  1  high for every ICMP byte of a packet, type byte first; low between packets
rx_data  in  8  ICMP byte
remote_mac  in  48  source MAC of current rx packet, valid on first rx_enable cycle
remote_ip  in  32  source IP of current rx packet, valid on first rx_enable cycle
tx_enable  in  1  arbiter grant, sampled only while tx_request high
tx_request  out  1  reply ready, awaiting grant
tx_active  out  1  reply bytes being driven
tx_data  out  8  reply byte stream
length  out  16  reply ICMP length (4 + payload bytes), stable from tx_request rise until tx_active falls
destination_mac  out  48  latched remote_mac
destination_ip  out  32  latched remote_ip
dst_unreachable  out  1  one-cycle pulse per received type-3 packet
drop_count  out  CNT_WIDTH  saturating count of discarded echo requests

Behaviour:
- Reset: state IDLE; tx_request, tx_active, dst_unreachable = 0; tx_data = 0; length = 0; drop_count = 0; buffer pointers cleared. Reset mid-operation aborts rx or tx immediately; tx_active is low on the cycle after reset is sampled.
- States: IDLE, HEADER, PAYLOAD, CHECK, TXREQ, TX, DISCARD.
- IDLE:
  - First rx_enable cycle: latch remote_mac/ip; clear sum and write pointer; add type byte to sum.
  - type 8 -> HEADER.
  - type 3 -> pulse dst_unreachable the next cycle, then DISCARD.
  - Any other type -> DISCARD.
- HEADER (bytes 1..3):
  - Code byte must be 0x00, else DISCARD.
  - Checksum bytes are summed, not stored.
  - rx_enable low here -> IDLE, no count.
  - Then PAYLOAD.
- PAYLOAD:
  - Each byte is written to the buffer and the pointer increments.
  - Sum: bytes at even offset from the ICMP start are added as the high byte, odd offset as the low byte. Use a 32-bit accumulator.
  - Write when the pointer already equals 2**DEPTH_LOG2 (overflow) -> DISCARD, drop_count+1.
  - rx_enable low -> CHECK.
- CHECK (1 cycle):
  - fold = sum[15:0] + sum[31:16] + carry.
  - If VERIFY_CSUM and fold != 0xFFFF -> IDLE, drop_count+1.
  - Otherwise compute the reply checksum as ~fold over payload only; type/code become 0 and are excluded. Keep a separate payload-only sum for this.
  - Set length = 4 + payload count, then TXREQ.
  - An odd payload count pads the final low byte with 0 in the sum.
- TXREQ:
  - tx_request = 1.
  - On tx_enable: tx_request = 0 next cycle; enter TX.
  - tx_active = 1 combinationally in the grant cycle.
  - tx_data in the grant cycle = 0x00 (type).
- TX:
  - tx_data sequence, one byte per cycle: 0x00, 0x00, csum[15:8], csum[7:0], then payload[0..n-1].
  - Buffer read is prefetched so payload[0] appears on cycle 4 with no bubble.
  - tx_active falls the cycle after the last byte; tx_data = 0 whenever tx_active is low.
  - Zero-length payload: exactly 4 bytes sent.
  - Then IDLE.
- Busy: rx_enable rising while in TXREQ/TX -> the new packet is ignored until rx_enable falls. drop_count+1 if its type byte is 8; a type-3 byte still pulses dst_unreachable.
- DISCARD: wait for rx_enable low -> IDLE. If rx_enable is already low on entry, return to IDLE the next cycle.
- drop_count holds at all-ones; it never wraps.
- dst_unreachable and a drop increment in the same cycle are independent.

Test Plan:
1. Echo request, id=0x1234 seq=0x0001, data 0xDE,0xAD,0xBE,0xEF, valid checksum -> tx_request, length=12; after grant tx_data = 00,00,csum_hi,csum_lo,12,34,00,01,DE,AD,BE,EF with a correct reply checksum, tx_active high exactly 12 cycles.
2. Same packet with checksum corrupted (VERIFY_CSUM=1) -> no tx_request, drop_count=1. With VERIFY_CSUM=0 -> the reply is sent.
3. Odd payload of 5 bytes -> length=9; reply checksum equals a golden model with zero padding.
4. DEPTH_LOG2=4, 17-byte payload -> DISCARD, drop_count+1, no request. Exactly 16 bytes -> reply length=20.
5. Type-3 packet -> single-cycle dst_unreachable pulse, no tx_request. A type-8 packet arriving during TX -> drop_count+1, the first reply is unaffected.
6. Reset asserted on TX byte 6 -> tx_active low next cycle, drop_count=0. A fresh echo afterwards is answered correctly.
